// File: rtl/fpsu_ret_pkg.sv
// Shared types and constants for the FP add/sub retire collector.
//
// Contents:
//   ret_entry_t             one buffered completion record {ret, flags, trap, port}
//   PORT_U1/PORT_U3/PORT_U5 source-port codes carried in ret_entry_t.port
//   FPCSR_TRAPEN_LSB/MSB    location of the trap-enable mask inside fpcsr
//   STALL_MARGIN            free slots that must remain before stall drops
//   port_code()             maps a port index (0..2) to its port code
package fpsu_ret_pkg;

    localparam int RET_CODE_W = 14;
    localparam int FLAG_W     = 6;
    localparam int PORT_W     = 2;

    localparam logic [PORT_W-1:0] PORT_U1 = 2'd0;
    localparam logic [PORT_W-1:0] PORT_U3 = 2'd1;
    localparam logic [PORT_W-1:0] PORT_U5 = 2'd2;

    localparam int FPCSR_TRAPEN_LSB = 0;
    localparam int FPCSR_TRAPEN_MSB = 5;

    // Two worst-case 3-wide cycles can land after stall is raised: one
    // while the registered stall is being computed, one before issue reacts.
    localparam int STALL_MARGIN = 6;

    typedef struct packed {
        logic [RET_CODE_W-1:0] ret;
        logic [FLAG_W-1:0]     flags;
        logic                  trap;
        logic [PORT_W-1:0]     port;
    } ret_entry_t;

    function automatic logic [PORT_W-1:0] port_code(input int idx);
        case (idx)
            0:       return PORT_U1;
            1:       return PORT_U3;
            default: return PORT_U5;
        endcase
    endfunction

endpackage

// File: rtl/fpsu_ret_collect_if.sv
// Bundle of all non-clock signals of the retire collector.
//
// master: the environment (FP unit completions, CSR, writeback consumer)
// slave : the collector itself
//
// Signals:
//   fpcsr[31:0]              FP control/status, [5:0] = trap-enable mask
//   uN_ret / uN_ret_en       completion return code and valid, N = 1,3,5
//   FOOFL0/1/2               exception flags for u1/u3/u5, same cycle as ret_en
//   flush                    pipeline flush
//   wb_valid/wb_ready        head record handshake
//   wb_ret/wb_flags/wb_trap/wb_port   head record fields
//   flag_or_en/flag_or       sticky-flag update for the CSR (1-cycle latency)
//   stall                    registered issue backpressure
//   err_ovf                  sticky overflow error
//
// Handshake: wb_valid is high whenever the FIFO holds at least one record and
// wb_ret/wb_flags/wb_trap/wb_port then describe the oldest one. A record is
// consumed on every rising clk edge where wb_valid && wb_ready (and no flush).
// wb_valid does not depend on wb_ready; the consumer may hold wb_ready high
// permanently. The completion ports have no ready: upstream must honour stall.
interface fpsu_ret_collect_if;
    import fpsu_ret_pkg::*;

    logic [31:0]           fpcsr;
    logic [RET_CODE_W-1:0] u1_ret;
    logic [RET_CODE_W-1:0] u3_ret;
    logic [RET_CODE_W-1:0] u5_ret;
    logic                  u1_ret_en;
    logic                  u3_ret_en;
    logic                  u5_ret_en;
    logic [FLAG_W-1:0]     FOOFL0;
    logic [FLAG_W-1:0]     FOOFL1;
    logic [FLAG_W-1:0]     FOOFL2;
    logic                  flush;
    logic                  wb_ready;
    logic                  wb_valid;
    logic [RET_CODE_W-1:0] wb_ret;
    logic [FLAG_W-1:0]     wb_flags;
    logic                  wb_trap;
    logic [PORT_W-1:0]     wb_port;
    logic                  flag_or_en;
    logic [FLAG_W-1:0]     flag_or;
    logic                  stall;
    logic                  err_ovf;

    modport master (
        output fpcsr, u1_ret, u3_ret, u5_ret, u1_ret_en, u3_ret_en, u5_ret_en,
               FOOFL0, FOOFL1, FOOFL2, flush, wb_ready,
        input  wb_valid, wb_ret, wb_flags, wb_trap, wb_port,
               flag_or_en, flag_or, stall, err_ovf
    );

    modport slave (
        input  fpcsr, u1_ret, u3_ret, u5_ret, u1_ret_en, u3_ret_en, u5_ret_en,
               FOOFL0, FOOFL1, FOOFL2, flush, wb_ready,
        output wb_valid, wb_ret, wb_flags, wb_trap, wb_port,
               flag_or_en, flag_or, stall, err_ovf
    );

endinterface

// File: rtl/fpsu_ret_fifo.sv
// Three-push / one-pop FIFO of ret_entry_t records.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush        empties the FIFO (rptr <= wptr) and drops same-cycle pushes/pop
//   npush        number of valid records in push_data (0..3), packed from slot 0
//   push_data    records to write at wptr, wptr+1, wptr+2
//   pop          consume the head (ignored when empty or flushing)
//   head         record at rptr (contents undefined when count == 0)
//   count        current occupancy
//   count_next   occupancy after this cycle's push/pop/flush
//   err_ovf      sticky: a push found too few free slots and records were dropped
//
// DEPTH must be a power of two and at least 8.
module fpsu_ret_fifo
    import fpsu_ret_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [1:0]                 npush,
    input  ret_entry_t                 push_data [3],
    input  logic                       pop,
    output ret_entry_t                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next,
    output logic                       err_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ret_entry_t    mem [DEPTH];
    // Pointers carry a wrap bit above the slot index.
    logic [CW-1:0] wptr;
    logic [CW-1:0] rptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] free_slots;
    logic [CW-1:0] count_nx;
    logic [1:0]    n_acc;
    logic          pop_ok;
    logic          ovf;

    assign pop_ok = pop & (count_q != '0) & ~flush;

    // A pop in the same cycle frees its slot for this cycle's pushes, so a
    // full FIFO can still accept one record while draining one.
    always_comb begin
        free_slots = CW'(DEPTH) - count_q + CW'(pop_ok);
        n_acc      = npush;
        ovf        = 1'b0;
        if (flush) begin
            n_acc = 2'd0;
        end else if (CW'(npush) > free_slots) begin
            // Keep the oldest (lowest-slot) records, drop the rest.
            n_acc = free_slots[1:0];
            ovf   = 1'b1;
        end
        if (flush) begin
            count_nx = '0;
        end else begin
            count_nx = count_q + CW'(n_acc) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            err_ovf <= 1'b0;
        end else begin
            wptr    <= wptr + CW'(n_acc);
            count_q <= count_nx;
            if (flush) begin
                rptr <= wptr;
            end else begin
                rptr <= rptr + CW'(pop_ok);
            end
            if (ovf) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (k < int'(n_acc)) begin
                    mem[wptr[AW-1:0] + AW'(k)] <= push_data[k];
                end
            end
        end
    end

    assign head       = mem[rptr[AW-1:0]];
    assign count      = count_q;
    assign count_next = count_nx;

endmodule

// File: rtl/fpsu_ret_collect.sv
// Retire/flag collector for the three-port (u1/u3/u5) SIMD FP add/sub unit.
// Packs each cycle's valid completions in u1,u3,u5 order into a 3-push FIFO,
// drains one record per cycle to writeback, produces the sticky-flag OR for
// the FP CSR and a registered issue stall.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  fpsu_ret_collect_if.slave (completions, fpcsr, flush, writeback
//        handshake, flag_or, stall, err_ovf)
module fpsu_ret_collect
    import fpsu_ret_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int RET_W = RET_CODE_W,
    parameter int FLG_W = FLAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    fpsu_ret_collect_if.slave        bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [2:0]       en;
    logic [RET_W-1:0] ret_in [3];
    logic [FLG_W-1:0] flg_in [3];
    logic [FLG_W-1:0] trap_en;
    ret_entry_t       slot [3];
    logic [1:0]       npush;
    logic [FLG_W-1:0] flag_any;

    ret_entry_t       head;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             head_valid;
    logic             fifo_ovf;

    logic             stall_q;
    logic             flag_or_en_q;
    logic [FLG_W-1:0] flag_or_q;
    logic             unused_csr;

    assign en        = {bus.u5_ret_en, bus.u3_ret_en, bus.u1_ret_en};
    assign ret_in[0] = bus.u1_ret;
    assign ret_in[1] = bus.u3_ret;
    assign ret_in[2] = bus.u5_ret;
    assign flg_in[0] = bus.FOOFL0;
    assign flg_in[1] = bus.FOOFL1;
    assign flg_in[2] = bus.FOOFL2;
    assign trap_en   = bus.fpcsr[FPCSR_TRAPEN_MSB:FPCSR_TRAPEN_LSB];
    assign unused_csr = ^bus.fpcsr[31:FPCSR_TRAPEN_MSB+1];

    // Compaction: the k-th valid port (in u1,u3,u5 order) lands in slot k.
    // The trap bit is frozen here so later fpcsr writes don't affect it.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            slot[k] = '0;
        end
        npush    = 2'd0;
        flag_any = '0;
        for (int p = 0; p < 3; p++) begin
            if (en[p]) begin
                slot[npush].ret   = ret_in[p];
                slot[npush].flags = flg_in[p];
                slot[npush].trap  = |(flg_in[p] & trap_en);
                slot[npush].port  = port_code(p);
                npush             = npush + 2'd1;
                flag_any          = flag_any | flg_in[p];
            end
        end
    end

    fpsu_ret_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.flush),
        .npush      (npush),
        .push_data  (slot),
        .pop        (head_valid & bus.wb_ready),
        .head       (head),
        .count      (count),
        .count_next (count_next),
        .err_ovf    (fifo_ovf)
    );

    assign head_valid = (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q      <= 1'b0;
            flag_or_en_q <= 1'b0;
            flag_or_q    <= '0;
        end else begin
            stall_q <= (CW'(DEPTH) - count_next) < CW'(STALL_MARGIN);
            if (bus.flush) begin
                flag_or_en_q <= 1'b0;
                flag_or_q    <= '0;
            end else begin
                flag_or_en_q <= (flag_any != '0);
                flag_or_q    <= flag_any;
            end
        end
    end

    // Head fields are forced to zero when empty so nothing stale is visible.
    assign bus.wb_valid   = head_valid;
    assign bus.wb_ret     = head_valid ? head.ret   : '0;
    assign bus.wb_flags   = head_valid ? head.flags : '0;
    assign bus.wb_trap    = head_valid & head.trap;
    assign bus.wb_port    = head_valid ? head.port  : '0;
    assign bus.flag_or_en = flag_or_en_q;
    assign bus.flag_or    = flag_or_q;
    assign bus.stall      = stall_q;
    assign bus.err_ovf    = fifo_ovf;

endmodule

// File: tb/tb_fpsu_ret_collect.sv
// Directed bench for fpsu_ret_collect: single push/pop, ordering and flag
// merge, trap capture, stall margin, overflow, full-boundary wrap, flush, reset.
module tb_fpsu_ret_collect;
    import fpsu_ret_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpsu_ret_collect_if bus ();

    fpsu_ret_collect #(
        .DEPTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [RET_CODE_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] en,
                         input logic [13:0] r1, input logic [13:0] r3, input logic [13:0] r5,
                         input logic [5:0] f0, input logic [5:0] f1, input logic [5:0] f2);
        bus.u1_ret_en = en[0];
        bus.u3_ret_en = en[1];
        bus.u5_ret_en = en[2];
        bus.u1_ret    = r1;
        bus.u3_ret    = r3;
        bus.u5_ret    = r5;
        bus.FOOFL0    = f0;
        bus.FOOFL1    = f1;
        bus.FOOFL2    = f2;
    endtask

    task automatic idle();
        drive(3'b000, 14'h0, 14'h0, 14'h0, 6'h0, 6'h0, 6'h0);
        bus.flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        bus.fpcsr    = 32'h0;
        bus.wb_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(bus.wb_valid), 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_ovf", 32'(bus.err_ovf), 32'h0);
        check("rst_flag_en", 32'(bus.flag_or_en), 32'h0);
        check("rst_flag_or", 32'(bus.flag_or), 32'h0);
        check("rst_count", 32'(dut.u_fifo.count), 32'h0);

        // Single push and pop; disabled u1 flags must not leak into flag_or
        bus.fpcsr    = 32'h4;
        bus.wb_ready = 1'b1;
        drive(3'b010, 14'h0, 14'h1A5, 14'h0, 6'h3F, 6'h04, 6'h0);
        step();
        idle();
        check("t1_valid", 32'(bus.wb_valid), 32'h1);
        check("t1_ret", 32'(bus.wb_ret), 32'h1A5);
        check("t1_port", 32'(bus.wb_port), 32'h1);
        check("t1_trap", 32'(bus.wb_trap), 32'h1);
        check("t1_flags", 32'(bus.wb_flags), 32'h04);
        check("t1_flag_en", 32'(bus.flag_or_en), 32'h1);
        check("t1_flag_or", 32'(bus.flag_or), 32'h04);
        step();
        check("t1_drained", 32'(bus.wb_valid), 32'h0);
        check("t1_flag_en_off", 32'(bus.flag_or_en), 32'h0);
        check("t1_flag_or_off", 32'(bus.flag_or), 32'h0);

        // Ordering and flag merge
        bus.fpcsr = 32'h0;
        drive(3'b111, 14'h11, 14'h22, 14'h33, 6'h01, 6'h02, 6'h08);
        step();
        idle();
        check("t2_ret0", 32'(bus.wb_ret), 32'h11);
        check("t2_port0", 32'(bus.wb_port), 32'h0);
        check("t2_trap0", 32'(bus.wb_trap), 32'h0);
        check("t2_flag_or", 32'(bus.flag_or), 32'h0B);
        check("t2_flag_en", 32'(bus.flag_or_en), 32'h1);
        check("t2_count", 32'(dut.u_fifo.count), 32'h3);
        check("t2_stall3", 32'(bus.stall), 32'h1);
        step();
        check("t2_ret1", 32'(bus.wb_ret), 32'h22);
        check("t2_port1", 32'(bus.wb_port), 32'h1);
        check("t2_flag_en_once", 32'(bus.flag_or_en), 32'h0);
        check("t2_stall2", 32'(bus.stall), 32'h0);
        step();
        check("t2_ret2", 32'(bus.wb_ret), 32'h33);
        check("t2_port2", 32'(bus.wb_port), 32'h2);
        step();
        check("t2_empty", 32'(bus.wb_valid), 32'h0);

        // Trap bit is captured at push time
        bus.wb_ready = 1'b0;
        bus.fpcsr    = 32'h10;
        drive(3'b001, 14'h2B, 14'h0, 14'h0, 6'h10, 6'h0, 6'h0);
        step();
        idle();
        bus.fpcsr = 32'h0;
        step();
        check("trap_kept", 32'(bus.wb_trap), 32'h1);
        check("trap_flags", 32'(bus.wb_flags), 32'h10);
        bus.wb_ready = 1'b1;
        step();
        check("trap_drained", 32'(bus.wb_valid), 32'h0);

        // Stall margin
        bus.wb_ready = 1'b0;
        drive(3'b111, 14'h101, 14'h102, 14'h103, 6'h0, 6'h0, 6'h0);
        step();
        check("t3_count3", 32'(dut.u_fifo.count), 32'h3);
        check("t3_stall3", 32'(bus.stall), 32'h1);
        drive(3'b111, 14'h104, 14'h105, 14'h106, 6'h0, 6'h0, 6'h0);
        step();
        idle();
        check("t3_count6", 32'(dut.u_fifo.count), 32'h6);
        check("t3_stall6", 32'(bus.stall), 32'h1);
        check("t3_no_ovf", 32'(bus.err_ovf), 32'h0);
        step();
        check("t3_hold6", 32'(dut.u_fifo.count), 32'h6);
        check("t3_no_ovf2", 32'(bus.err_ovf), 32'h0);
        check("t3_head", 32'(bus.wb_ret), 32'h101);

        // Overflow
        drive(3'b111, 14'h107, 14'h108, 14'h109, 6'h0, 6'h0, 6'h0);
        step();
        idle();
        check("t4_count", 32'(dut.u_fifo.count), 32'h8);
        check("t4_ovf", 32'(bus.err_ovf), 32'h1);
        check("t4_head", 32'(bus.wb_ret), 32'h101);
        step();
        check("t4_ovf_sticky", 32'(bus.err_ovf), 32'h1);
        do_reset();
        check("t4_ovf_clr", 32'(bus.err_ovf), 32'h0);
        check("t4_count_clr", 32'(dut.u_fifo.count), 32'h0);

        // Full boundary: fill to 8 exactly, then push 1 / pop 1
        drive(3'b111, 14'h201, 14'h202, 14'h203, 6'h0, 6'h0, 6'h0);
        step();
        drive(3'b111, 14'h204, 14'h205, 14'h206, 6'h0, 6'h0, 6'h0);
        step();
        drive(3'b011, 14'h207, 14'h208, 14'h0, 6'h0, 6'h0, 6'h0);
        step();
        check("t5_full", 32'(dut.u_fifo.count), 32'h8);
        check("t5_full_ovf", 32'(bus.err_ovf), 32'h0);
        check("t5_full_stall", 32'(bus.stall), 32'h1);
        bus.wb_ready = 1'b1;
        drive(3'b100, 14'h0, 14'h0, 14'h209, 6'h0, 6'h0, 6'h0);
        step();
        check("t5_count", 32'(dut.u_fifo.count), 32'h8);
        check("t5_no_ovf", 32'(bus.err_ovf), 32'h0);
        check("t5_head", 32'(bus.wb_ret), 32'h202);
        exp_q = {14'h202, 14'h203, 14'h204, 14'h205, 14'h206, 14'h207, 14'h208, 14'h209};
        for (int i = 0; i < 20; i++) begin
            check("wrap_head", 32'(bus.wb_ret), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            drive(3'b001, 14'(14'h20A + i), 14'h0, 14'h0, 6'h0, 6'h0, 6'h0);
            step();
            exp_q.push_back(14'(14'h20A + i));
        end
        check("wrap_count", 32'(dut.u_fifo.count), 32'h8);
        check("wrap_no_ovf", 32'(bus.err_ovf), 32'h0);
        check("wrap_last_head", 32'(bus.wb_ret), 32'(exp_q[0]));
        idle();
        bus.wb_ready = 1'b0;

        // Flush with count 5 and a 2-port push carrying flags
        do_reset();
        drive(3'b111, 14'h301, 14'h302, 14'h303, 6'h0, 6'h0, 6'h0);
        step();
        drive(3'b011, 14'h304, 14'h305, 14'h0, 6'h0, 6'h0, 6'h0);
        step();
        check("t6_count5", 32'(dut.u_fifo.count), 32'h5);
        check("t6_stall5", 32'(bus.stall), 32'h1);
        bus.flush    = 1'b1;
        bus.wb_ready = 1'b1;
        drive(3'b011, 14'h306, 14'h307, 14'h0, 6'h3F, 6'h3F, 6'h0);
        step();
        idle();
        check("fl_valid", 32'(bus.wb_valid), 32'h0);
        check("fl_flag_en", 32'(bus.flag_or_en), 32'h0);
        check("fl_stall", 32'(bus.stall), 32'h0);
        check("fl_count", 32'(dut.u_fifo.count), 32'h0);
        drive(3'b100, 14'h0, 14'h0, 14'h3AA, 6'h0, 6'h0, 6'h0);
        step();
        idle();
        check("fl_after_valid", 32'(bus.wb_valid), 32'h1);
        check("fl_after_ret", 32'(bus.wb_ret), 32'h3AA);
        check("fl_after_port", 32'(bus.wb_port), 32'h2);
        step();
        check("fl_after_drain", 32'(bus.wb_valid), 32'h0);

        // Same scenario using rst
        bus.wb_ready = 1'b0;
        bus.fpcsr    = 32'h3F;
        drive(3'b111, 14'h401, 14'h402, 14'h403, 6'h01, 6'h01, 6'h01);
        step();
        drive(3'b011, 14'h404, 14'h405, 14'h0, 6'h02, 6'h02, 6'h0);
        step();
        check("t7_count5", 32'(dut.u_fifo.count), 32'h5);
        check("t7_flag_en", 32'(bus.flag_or_en), 32'h1);
        rst          = 1'b1;
        bus.wb_ready = 1'b1;
        drive(3'b011, 14'h406, 14'h407, 14'h0, 6'h3F, 6'h3F, 6'h0);
        step();
        rst = 1'b0;
        idle();
        check("r_valid", 32'(bus.wb_valid), 32'h0);
        check("r_ret", 32'(bus.wb_ret), 32'h0);
        check("r_flags", 32'(bus.wb_flags), 32'h0);
        check("r_trap", 32'(bus.wb_trap), 32'h0);
        check("r_port", 32'(bus.wb_port), 32'h0);
        check("r_flag_en", 32'(bus.flag_or_en), 32'h0);
        check("r_flag_or", 32'(bus.flag_or), 32'h0);
        check("r_stall", 32'(bus.stall), 32'h0);
        check("r_ovf", 32'(bus.err_ovf), 32'h0);
        step();
        check("r_still_empty", 32'(bus.wb_valid), 32'h0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpsu_ret_collect.md
Name: fpsu_ret_collect

Overview:
- Downstream retire/flag collector for the three-port (u1/u3/u5) SIMD FP add/sub unit.
- Each cycle it takes up to three completion records: a 14-bit return code plus a 6-bit exception-flag vector per port.
- It orders them u1, u3, u5 and buffers them in a multi-push, single-pop FIFO, then drains one record per cycle to the writeback/ROB interface.
- It also produces the per-cycle sticky-flag OR for the FP CSR and a registered stall that backpressures issue to the FP unit.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two and at least 8.
- RET_W, 14, return-code width.
- FLG_W, 6, exception-flag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fpcsr  in  32  FP control/status; bits [5:0] are the trap-enable mask.
- u1_ret / u3_ret / u5_ret  in  14 each  completion return code.
- u1_ret_en / u3_ret_en / u5_ret_en  in  1 each  completion valid.
- FOOFL0 / FOOFL1 / FOOFL2  in  6 each  exception flags for u1/u3/u5, aligned with the same-cycle ret_en.
- flush  in  1  pipeline flush.
- wb_ready  in  1  writeback accepts the head record.
- wb_valid  out  1  head record valid.
- wb_ret  out  14  head return code.
- wb_flags  out  6  head flags.
- wb_trap  out  1  head record traps.
- wb_port  out  2  source port: 0=u1, 1=u3, 2=u5.
- flag_or_en  out  1  sticky-flag update strobe.
- flag_or  out  6  flags to OR into the CSR sticky field.
- stall  out  1  stop issuing to the FP unit.
- err_ovf  out  1  sticky overflow error.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, read/write pointers 0, count 0. A reset mid-operation discards all buffered entries with no drain.
- Push:
  - npush = u1_ret_en + u3_ret_en + u5_ret_en, range 0..3.
  - Valid records are written in fixed order u1, u3, u5 into consecutive slots starting at wptr.
  - wptr advances by npush modulo DEPTH.
  - Pointers carry one extra wrap bit to distinguish full from empty.
- Entry contents: {ret, flags, trap, port}, where trap = |(flags & fpcsr[5:0]). fpcsr is sampled in the push cycle; later fpcsr changes do not alter stored trap bits.
- Pop:
  - Head fields are driven directly from the slot at rptr; wb_valid = (count != 0).
  - A pop occurs when wb_valid & wb_ready; rptr then advances by 1.
  - Data on wb_* is don't-care when wb_valid=0. wb_valid is never asserted with stale data.
- Latency: a record pushed in cycle N can appear on wb_* in cycle N+1 at the earliest. There is no same-cycle bypass.
- Count update: count_next = count + npush - pop. Simultaneous push and pop is allowed, including when the FIFO is full and a pop frees a slot.
- Stall:
  - stall is registered: stall <= (DEPTH - count_next) < 6.
  - Upstream honours stall starting the cycle after it is asserted. The 6-slot margin covers two worst-case 3-wide cycles.
- Overflow: if count + npush - pop > DEPTH, the excess records are dropped, err_ovf sets, and it stays set until rst.
- Flag OR:
  - flag_or <= OR of FOOFLn over the ports whose ret_en is asserted.
  - flag_or_en <= (that OR != 0).
  - Latency is 1 cycle. The output is zero when no port is valid.
- Flush:
  - Clears count and sets rptr=wptr.
  - Drops same-cycle pushes and suppresses the same-cycle flag_or update (flag_or_en=0 next cycle).
  - stall deasserts on the next cycle.
  - A pop in the flush cycle is ignored.

Decomposition:
- Package fpsu_ret_pkg holds:
  - the entry struct {ret[13:0], flags[5:0], trap, port[1:0]};
  - the port-code constants;
  - the FPCSR_TRAPEN_LSB/MSB offsets;
  - the stall margin constant (6).
- Sub-module fpsu_ret_fifo: parameterised 3-push/1-pop FIFO with count, pointers and overflow detect.
- The top level does the compaction of valid records into consecutive slots, the trap computation, the flag OR and the stall register.

Test Plan:
- Single push and pop: reset, then u3_ret_en=1 with u3_ret=0x1A5, FOOFL1=0x04, fpcsr[5:0]=0x04, wb_ready=1. Expected next cycle: wb_valid=1, wb_ret=0x1A5, wb_port=1, wb_trap=1, flag_or_en=1, flag_or=0x04.
- Ordering and flag merge: one cycle with all three ports valid (rets 0x11/0x22/0x33, flags 0x01/0x02/0x08) and wb_ready=1. Expected: wb_ret sequence 0x11, 0x22, 0x33 over 3 cycles; flag_or=0x0B once.
- Stall margin: wb_ready=0, three pushes per cycle. Expected: count 3 then 6; stall=1 in the cycle after count reaches 3; no err_ovf if upstream stops then.
- Overflow: keep pushing 3 per cycle while stall=1 and wb_ready=0. Expected: count saturates at 8, err_ovf=1, and the head data is the first record pushed.
- Full-boundary simultaneous event: count=8, wb_ready=1, one push. Expected: count stays 8, no overflow; pointer wrap verified over 20 cycles of 1-push/1-pop.
- Flush and reset: flush while count=5 together with a 2-port push whose flags are 0x3F. Expected next cycle: wb_valid=0, flag_or_en=0, stall=0. Repeat the scenario using rst: all outputs return to 0.
